// File: rtl/icache_pkg.sv
// icache_pkg: shared constants, FSM state type and address-split helpers
// for the wrap-refill instruction cache.
//   BURST_* / SIZE_4B / RESP_OKAY : AXI4 encodings used on AR/R
//   state_t                      : controller state (IDLE..RESP)
//   addr_off/addr_idx/addr_tag   : split a byte address into line fields
package icache_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [2:0] SIZE_4B     = 3'b010;
    localparam logic [1:0] RESP_OKAY   = 2'b00;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOOKUP  = 3'd1,
        MISS_AR = 3'd2,
        MISS_R  = 3'd3,
        RESP    = 3'd4
    } state_t;

    // Word offset within the line (byte bits [1:0] dropped).
    function automatic logic [31:0] addr_off(input logic [31:0] a, input int off_w);
        return (a >> 2) & ((32'd1 << off_w) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_idx(input logic [31:0] a, input int off_w,
                                             input int idx_w);
        return (a >> (off_w + 2)) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_tag(input logic [31:0] a, input int off_w,
                                             input int idx_w);
        return a >> (off_w + idx_w + 2);
    endfunction

endpackage

// File: rtl/icache_refill_ctl.sv
// icache_refill_ctl: drives the AR request and tracks the R beats of one
// WRAP line refill.
//   i_state          : controller state from the top
//   i_addr_w         : registered fetch word address (addr[31:2])
//   i_off            : requested word offset (critical word)
//   o_ar*/i_arready  : AXI4 AR channel
//   o_rready, i_r*   : AXI4 R channel handshake/status (data goes to the top)
//   o_ar_done        : AR handshake this cycle
//   o_beat_we/off    : write the current R beat into the line at this offset
//   o_first          : current beat is the critical word
//   o_done / o_err   : last beat this cycle / refill error including this beat
module icache_refill_ctl
    import icache_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int OFF_W      = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  state_t           i_state,
    input  logic [29:0]      i_addr_w,
    input  logic [OFF_W-1:0] i_off,
    output logic             o_arvalid,
    input  logic             i_arready,
    output logic [31:0]      o_araddr,
    output logic [3:0]       o_arid,
    output logic [7:0]       o_arlen,
    output logic [2:0]       o_arsize,
    output logic [1:0]       o_arburst,
    output logic             o_rready,
    input  logic             i_rvalid,
    input  logic [1:0]       i_rresp,
    input  logic             i_rlast,
    output logic             o_ar_done,
    output logic             o_beat_we,
    output logic [OFF_W-1:0] o_beat_off,
    output logic             o_first,
    output logic             o_done,
    output logic             o_err
);

    logic [OFF_W-1:0] r_off;
    logic [OFF_W-1:0] r_cnt;
    logic             r_first;
    logic             r_err;
    logic             w_beat;

    // AR fields come straight from state and the registered address, so they
    // stay stable for as long as arvalid is high.
    assign o_arvalid = (i_state == MISS_AR);
    assign o_araddr  = {i_addr_w, 2'b00};
    assign o_arid    = 4'd0;
    assign o_arlen   = 8'(LINE_WORDS - 1);
    assign o_arsize  = SIZE_4B;
    assign o_arburst = BURST_WRAP;
    assign o_rready  = (i_state == MISS_R);

    assign w_beat     = (i_state == MISS_R) && i_rvalid;
    assign o_ar_done  = (i_state == MISS_AR) && i_arready;
    assign o_beat_we  = w_beat;
    assign o_beat_off = r_off;
    assign o_first    = r_first;
    assign o_done     = w_beat && i_rlast;
    // rlast before the full line counts as an error so a short line never
    // gets marked valid.
    assign o_err      = r_err || (i_rresp != RESP_OKAY) ||
                        (i_rlast && (r_cnt != OFF_W'(LINE_WORDS - 1)));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_off   <= '0;
            r_cnt   <= '0;
            r_first <= 1'b0;
            r_err   <= 1'b0;
        end else if (o_ar_done) begin
            r_off   <= i_off;
            r_cnt   <= '0;
            r_first <= 1'b1;
            r_err   <= 1'b0;
        end else if (w_beat) begin
            r_off   <= r_off + OFF_W'(1);   // wraps mod LINE_WORDS
            r_cnt   <= r_cnt + OFF_W'(1);
            r_first <= 1'b0;
            if (i_rresp != RESP_OKAY) r_err <= 1'b1;
        end
    end

endmodule

// File: rtl/icache_wrap_refill.sv
// icache_wrap_refill: direct-mapped read-only I-cache with critical-word-first
// WRAP refill over AXI4 and a fence.i invalidate.
//   clock/reset         : clock, async active-low reset
//   req_*               : IFU fetch request (valid/ready/addr)
//   rsp_*               : fetch response (valid/ready/data/err)
//   fence_i             : invalidate all lines
//   ar*/r*              : AXI4 read master (rid ignored)
module icache_wrap_refill
    import icache_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    input  logic        fence_i,
    output logic        arvalid,
    input  logic        arready,
    output logic [31:0] araddr,
    output logic [3:0]  arid,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    input  logic        rvalid,
    output logic        rready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic [3:0]  rid
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - OFF_W - IDX_W;

    state_t           r_state, w_state_nxt;
    logic [31:0]      r_addr;
    logic [SETS-1:0]  r_valid;
    logic [TAG_W-1:0] r_tag  [SETS];
    logic [31:0]      r_data [SETS][LINE_WORDS];
    logic [31:0]      r_rsp_data;
    logic             r_rsp_err;
    logic             r_fence_pend;

    logic [OFF_W-1:0] w_off;
    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic             w_hit;
    logic             w_to_idle;
    logic             w_ar_done, w_beat_we, w_first, w_done, w_err;
    logic [OFF_W-1:0] w_beat_off;
    logic             w_unused;

    assign w_unused = ^rid;

    assign w_off = OFF_W'(addr_off(r_addr, OFF_W));
    assign w_idx = IDX_W'(addr_idx(r_addr, OFF_W, IDX_W));
    assign w_tag = TAG_W'(addr_tag(r_addr, OFF_W, IDX_W));
    assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

    assign rsp_data = r_rsp_data;
    assign rsp_err  = r_rsp_err;

    icache_refill_ctl #(
        .LINE_WORDS (LINE_WORDS),
        .OFF_W      (OFF_W)
    ) u_refill (
        .clock      (clock),
        .reset      (reset),
        .i_state    (r_state),
        .i_addr_w   (r_addr[31:2]),
        .i_off      (w_off),
        .o_arvalid  (arvalid),
        .i_arready  (arready),
        .o_araddr   (araddr),
        .o_arid     (arid),
        .o_arlen    (arlen),
        .o_arsize   (arsize),
        .o_arburst  (arburst),
        .o_rready   (rready),
        .i_rvalid   (rvalid),
        .i_rresp    (rresp),
        .i_rlast    (rlast),
        .o_ar_done  (w_ar_done),
        .o_beat_we  (w_beat_we),
        .o_beat_off (w_beat_off),
        .o_first    (w_first),
        .o_done     (w_done),
        .o_err      (w_err)
    );

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_state_nxt = LOOKUP;
            end
            LOOKUP:  w_state_nxt = w_hit ? RESP : MISS_AR;
            MISS_AR: if (w_ar_done) w_state_nxt = MISS_R;
            MISS_R:  if (w_done) w_state_nxt = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_to_idle = (r_state == RESP) && rsp_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_valid      <= '0;
            r_rsp_data   <= '0;
            r_rsp_err    <= 1'b0;
            r_fence_pend <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == IDLE) && req_valid) r_addr <= req_addr;
            if ((r_state == LOOKUP) && w_hit) begin
                r_rsp_data <= r_data[w_idx][w_off];
                r_rsp_err  <= 1'b0;
            end
            if (w_beat_we && w_first) r_rsp_data <= rdata;
            if (w_done) begin
                r_rsp_err      <= w_err;
                r_valid[w_idx] <= !w_err;
            end
            // A fence outside IDLE is deferred to the return to IDLE so the
            // line being filled is installed and then dropped with the rest.
            if (r_state == IDLE) begin
                if (fence_i) r_valid <= '0;
            end else if (w_to_idle && (r_fence_pend || fence_i)) begin
                r_valid      <= '0;
                r_fence_pend <= 1'b0;
            end else if (fence_i) begin
                r_fence_pend <= 1'b1;
            end
        end
    end

    // Data and tag arrays are qualified by r_valid, so they need no reset.
    always_ff @(posedge clock) begin
        if (w_beat_we) r_data[w_idx][w_beat_off] <= rdata;
        if (w_done && !w_err) r_tag[w_idx] <= w_tag;
    end

endmodule

// File: tb/tb_icache_wrap_refill.sv
module tb_icache_wrap_refill;

    logic        clock, reset;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err, fence_i;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid, rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [3:0]  rid;

    int nvec = 0;
    int nerr = 0;

    icache_wrap_refill dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .fence_i(fence_i),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .rlast(rlast), .rid(rid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- AXI read slave (RAM with wrap support) ----------------
    int          ar_cnt = 0;
    int          err_beat = -1;
    int          early_last = -1;
    logic [31:0] cap_araddr;
    logic [7:0]  cap_arlen;
    logic [2:0]  cap_arsize;
    logic [1:0]  cap_arburst;
    logic [3:0]  cap_arid;

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        return 32'hA000_0000 | (a & 32'h00FF_FFFC);
    endfunction

    initial begin
        bit          s_busy, ar_hs, r_hs;
        int          s_beat, s_len;
        logic [31:0] s_addr, lb, a;
        s_busy = 0; ar_hs = 0; r_hs = 0; s_beat = 0; s_len = 0; s_addr = '0;
        arready = 0; rvalid = 0; rdata = '0; rresp = 2'b00; rlast = 0; rid = 4'd0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                s_busy = 0; ar_hs = 0; r_hs = 0;
                arready = 0; rvalid = 0; rlast = 0; rresp = 2'b00;
            end else begin
                if (ar_hs) begin s_busy = 1; s_beat = 0; ar_hs = 0; end
                if (r_hs) begin
                    r_hs = 0;
                    if (rlast) s_busy = 0;
                    s_beat++;
                end
                arready = 0; rvalid = 0; rlast = 0; rresp = 2'b00;
                if (!s_busy && arvalid) begin
                    arready = 1; ar_hs = 1; ar_cnt++;
                    s_addr = araddr; s_len = int'(arlen);
                    cap_araddr = araddr; cap_arlen = arlen; cap_arsize = arsize;
                    cap_arburst = arburst; cap_arid = arid;
                end else if (s_busy) begin
                    lb = 32'((s_len + 1) * 4);
                    a  = (s_addr & ~(lb - 1)) | ((s_addr + 32'(s_beat * 4)) & (lb - 1));
                    rvalid = 1;
                    rdata  = ram_word(a);
                    rresp  = (s_beat == err_beat) ? 2'b10 : 2'b00;
                    rlast  = (s_beat == s_len) || (s_beat == early_last);
                    r_hs   = rready;
                end
            end
        end
    end

    // ---------------- IFU-side helpers ----------------
    task automatic send_req(input logic [31:0] addr, input logic fen);
        int k = 0;
        @(negedge clock);
        while (!req_ready && k < 100) begin @(negedge clock); k++; end
        if (k >= 100) chk("req_ready_timeout", 32'(k), 32'd0);
        req_valid = 1; req_addr = addr; fence_i = fen;
        @(negedge clock);
        req_valid = 0; fence_i = 0;
    endtask

    task automatic get_rsp(output logic [31:0] d, output logic e);
        int k = 0;
        while (!rsp_valid && k < 100) begin @(negedge clock); k++; end
        if (k >= 100) chk("rsp_timeout", 32'(k), 32'd0);
        d = rsp_data; e = rsp_err;
        rsp_ready = 1;
        @(negedge clock);
        rsp_ready = 0;
    endtask

    task automatic wait_rready();
        int k = 0;
        while (!rready && k < 100) begin @(negedge clock); k++; end
        if (k >= 100) chk("rready_timeout", 32'(k), 32'd0);
    endtask

    task automatic fetch(input logic [31:0] addr, input string tag,
                         input logic [31:0] exp_d, input logic exp_e, input int exp_ars);
        logic [31:0] d;
        logic        e;
        int          a0;
        a0 = ar_cnt;
        send_req(addr, 1'b0);
        get_rsp(d, e);
        chk({tag, "_data"}, d, exp_d);
        chk({tag, "_err"}, 32'(e), 32'(exp_e));
        chk({tag, "_ar_count"}, 32'(ar_cnt - a0), 32'(exp_ars));
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        int          a0;
        reset = 0; req_valid = 0; req_addr = '0; rsp_ready = 0; fence_i = 0;
        repeat (3) @(negedge clock);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_arvalid", 32'(arvalid), 32'd0);
        chk("rst_rready", 32'(rready), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        reset = 1;
        @(negedge clock);

        // Cold miss, critical word first
        fetch(32'h8000_0008, "cold", 32'hA000_0008, 1'b0, 1);
        chk("cold_araddr", cap_araddr, 32'h8000_0008);
        chk("cold_arlen", 32'(cap_arlen), 32'd3);
        chk("cold_arsize", 32'(cap_arsize), 32'd2);
        chk("cold_arburst", 32'(cap_arburst), 32'd2);
        chk("cold_arid", 32'(cap_arid), 32'd0);

        // Hit latency: LOOKUP cycle then RESP
        a0 = ar_cnt;
        send_req(32'h8000_0000, 1'b0);
        chk("hit_lookup_no_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clock);
        chk("hit_rsp_valid", 32'(rsp_valid), 32'd1);
        get_rsp(d, e);
        chk("hit0_data", d, 32'hA000_0000);
        chk("hit0_no_ar", 32'(ar_cnt - a0), 32'd0);
        fetch(32'h8000_0004, "hit1", 32'hA000_0004, 1'b0, 0);
        fetch(32'h8000_000C, "hit3", 32'hA000_000C, 1'b0, 0);

        // Conflict on index 0
        fetch(32'h8000_0100, "conf_new", 32'hA000_0100, 1'b0, 1);
        fetch(32'h8000_0000, "conf_old", 32'hA000_0000, 1'b0, 1);

        // Fence in IDLE, then fence together with a request
        @(negedge clock); fence_i = 1; @(negedge clock); fence_i = 0;
        fetch(32'h8000_0000, "fence_idle", 32'hA000_0000, 1'b0, 1);
        a0 = ar_cnt;
        send_req(32'h8000_0000, 1'b1);
        get_rsp(d, e);
        chk("fence_req_data", d, 32'hA000_0000);
        chk("fence_req_ar", 32'(ar_cnt - a0), 32'd1);

        // Fence during MISS_R: response intact, line invalid afterwards
        a0 = ar_cnt;
        send_req(32'h8000_0010, 1'b0);
        wait_rready();
        fence_i = 1; @(negedge clock); fence_i = 0;
        get_rsp(d, e);
        chk("fence_mr_data", d, 32'hA000_0010);
        chk("fence_mr_err", 32'(e), 32'd0);
        chk("fence_mr_ar", 32'(ar_cnt - a0), 32'd1);
        fetch(32'h8000_0010, "fence_mr_refetch", 32'hA000_0010, 1'b0, 1);

        // Error response on beat 2, then a clean refetch
        err_beat = 2;
        fetch(32'h8000_0020, "rresp_err", 32'hA000_0020, 1'b1, 1);
        err_beat = -1;
        fetch(32'h8000_0020, "rresp_refetch", 32'hA000_0020, 1'b0, 1);

        // Early rlast after two beats
        early_last = 1;
        fetch(32'h8000_0030, "early_last", 32'hA000_0030, 1'b1, 1);
        early_last = -1;

        // Response backpressure on a hit
        send_req(32'h8000_0024, 1'b0);
        @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_data", rsp_data, 32'hA000_0024);
            chk("bp_rsp_err", 32'(rsp_err), 32'd0);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            @(negedge clock);
        end
        get_rsp(d, e);
        chk("bp_final_data", d, 32'hA000_0024);

        // Async reset in the middle of a refill
        send_req(32'h8000_0040, 1'b0);
        wait_rready();
        #2 reset = 0;
        #1;
        chk("mrst_arvalid", 32'(arvalid), 32'd0);
        chk("mrst_rready", 32'(rready), 32'd0);
        chk("mrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mrst_req_ready", 32'(req_ready), 32'd1);
        repeat (2) @(negedge clock);
        reset = 1;
        fetch(32'h8000_0020, "mrst_valid_cleared", 32'hA000_0020, 1'b0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
